// File: rtl/fir_structs_pkg.sv
// rtl/fir_structs_pkg.sv - shared coefficient types, tap constants and bank-state enum for firc
package fir_structs;

  localparam int NTAP_UNIQUE = 15;
  localparam int CW          = 27;

  typedef struct packed {
    logic signed [CW-1:0] I;
    logic signed [CW-1:0] Q;
  } Coef;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    PEND = 2'd2
  } bank_state_e;

endpackage

// File: rtl/coef_bank_ctrl_if.sv
// rtl/coef_bank_ctrl_if.sv - coefficient write bus (PushCoef/CoefAddr/CoefI/CoefQ)
interface coef_bank_ctrl_if;
  import fir_structs::*;

  logic                 PushCoef;
  logic [4:0]           CoefAddr;
  logic signed [CW-1:0] CoefI;
  logic signed [CW-1:0] CoefQ;

  modport master (output PushCoef, output CoefAddr, output CoefI, output CoefQ);
  modport slave  (input  PushCoef, input  CoefAddr, input  CoefI, input  CoefQ);

endinterface

// File: rtl/coef_bank_reg.sv
// rtl/coef_bank_reg.sv - NTAP_UNIQUE-entry Coef register file, single write port, async clear
module coef_bank_reg
  import fir_structs::*;
(
  input  logic                         clk,
  input  logic                         Reset,
  input  logic                         i_we,
  input  logic [4:0]                   i_addr,
  input  Coef                          i_data,
  output Coef [NTAP_UNIQUE-1:0]        o_bank
);

  Coef [NTAP_UNIQUE-1:0] r_bank;

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      r_bank <= '0;
    end else begin
      for (int k = 0; k < NTAP_UNIQUE; k++) begin
        if (i_we && (i_addr == 5'(k))) r_bank[k] <= i_data;
      end
    end
  end

  assign o_bank = r_bank;

endmodule

// File: rtl/coef_bank_ctrl.sv
// rtl/coef_bank_ctrl.sv - double-buffered FIR coefficient manager with swap-on-idle
// Optional readback port enabled by COEF_BANK_READBACK_EN.
module coef_bank_ctrl
  import fir_structs::*;
(
  input  logic                   clk,
  input  logic                   Reset,
  coef_bank_ctrl_if.slave        wr,
  input  logic                   DpBusy,
  output Coef [NTAP_UNIQUE-1:0]  ActCoef,
  output logic                   CoefValid,
  output logic                   SwapPending,
  output logic                   SwapPulse,
  output logic                   CoefErr
`ifdef COEF_BANK_READBACK_EN
  ,
  input  logic [4:0]             RdAddr,
  output logic signed [CW-1:0]   RdI,
  output logic signed [CW-1:0]   RdQ
`endif
);

  Coef [NTAP_UNIQUE-1:0] w_shadow;
  Coef [NTAP_UNIQUE-1:0] r_act;
  Coef                   w_wr_coef;
  logic [NTAP_UNIQUE-1:0] r_mask;
  logic [NTAP_UNIQUE-1:0] w_wr_bit;
  logic [NTAP_UNIQUE-1:0] w_mask_nxt;
  bank_state_e           r_state;
  bank_state_e           w_state_nxt;
  logic                  w_valid_wr;
  logic                  w_bad_wr;
  logic                  w_swap;
  logic                  r_valid;
  logic                  r_swap_pulse;
  logic                  r_err;

  assign w_valid_wr = wr.PushCoef && (wr.CoefAddr < 5'(NTAP_UNIQUE));
  assign w_bad_wr   = wr.PushCoef && !(wr.CoefAddr < 5'(NTAP_UNIQUE));
  assign w_swap     = (r_state == PEND) && !DpBusy;
  assign w_wr_coef  = '{I: wr.CoefI, Q: wr.CoefQ};
  assign w_wr_bit   = w_valid_wr ? (NTAP_UNIQUE'(1) << wr.CoefAddr) : '0;

  // A swap consumes the old set, so a simultaneous write starts the next set fresh.
  assign w_mask_nxt = w_swap ? w_wr_bit : (r_mask | w_wr_bit);

  always_comb begin
    w_state_nxt = IDLE;
    if (&w_mask_nxt)      w_state_nxt = PEND;
    else if (|w_mask_nxt) w_state_nxt = LOAD;
  end

  coef_bank_reg u_shadow (
    .clk    (clk),
    .Reset  (Reset),
    .i_we   (w_valid_wr),
    .i_addr (wr.CoefAddr),
    .i_data (w_wr_coef),
    .o_bank (w_shadow)
  );

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      r_act        <= '0;
      r_mask       <= '0;
      r_state      <= IDLE;
      r_valid      <= 1'b0;
      r_swap_pulse <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      if (w_swap) begin
        r_act   <= w_shadow;
        r_valid <= 1'b1;
      end
      r_mask       <= w_mask_nxt;
      r_state      <= w_state_nxt;
      r_swap_pulse <= w_swap;
      r_err        <= w_bad_wr;
    end
  end

  assign ActCoef     = r_act;
  assign CoefValid   = r_valid;
  assign SwapPending = (r_state == PEND);
  assign SwapPulse   = r_swap_pulse;
  assign CoefErr     = r_err;

`ifdef COEF_BANK_READBACK_EN
  logic signed [CW-1:0] r_rd_i;
  logic signed [CW-1:0] r_rd_q;

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      r_rd_i <= '0;
      r_rd_q <= '0;
    end else if (RdAddr < 5'(NTAP_UNIQUE)) begin
      r_rd_i <= r_act[RdAddr[3:0]].I;
      r_rd_q <= r_act[RdAddr[3:0]].Q;
    end else begin
      r_rd_i <= '0;
      r_rd_q <= '0;
    end
  end

  assign RdI = r_rd_i;
  assign RdQ = r_rd_q;
`endif

endmodule

// File: tb/tb_coef_bank_ctrl.sv
// tb/tb_coef_bank_ctrl.sv - directed self-checking bench for coef_bank_ctrl
module tb_coef_bank_ctrl;
  import fir_structs::*;

  logic clk;
  logic Reset;
  logic DpBusy;
  Coef [NTAP_UNIQUE-1:0] ActCoef;
  logic CoefValid, SwapPending, SwapPulse, CoefErr;
  int n_checks;
  int n_fail;

  coef_bank_ctrl_if wr_if ();

`ifdef COEF_BANK_READBACK_EN
  logic [4:0]           RdAddr;
  logic signed [CW-1:0] RdI;
  logic signed [CW-1:0] RdQ;
`endif

  coef_bank_ctrl dut (
    .clk         (clk),
    .Reset       (Reset),
    .wr          (wr_if.slave),
    .DpBusy      (DpBusy),
    .ActCoef     (ActCoef),
    .CoefValid   (CoefValid),
    .SwapPending (SwapPending),
    .SwapPulse   (SwapPulse),
    .CoefErr     (CoefErr)
`ifdef COEF_BANK_READBACK_EN
    ,
    .RdAddr      (RdAddr),
    .RdI         (RdI),
    .RdQ         (RdQ)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the following negedge with PushCoef dropped.
  task automatic push(input int a, input int i, input int q);
    wr_if.PushCoef = 1'b1;
    wr_if.CoefAddr = 5'(a);
    wr_if.CoefI    = CW'(i);
    wr_if.CoefQ    = CW'(q);
    @(negedge clk);
    wr_if.PushCoef = 1'b0;
  endtask

  task automatic load_set(input int base, input int skip);
    for (int a = 0; a < NTAP_UNIQUE; a++) begin
      if (a != skip) push(a, base + a, -(base + a));
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    Reset    = 1'b1;
    DpBusy   = 1'b0;
    wr_if.PushCoef = 1'b0;
    wr_if.CoefAddr = '0;
    wr_if.CoefI    = '0;
    wr_if.CoefQ    = '0;
`ifdef COEF_BANK_READBACK_EN
    RdAddr = '0;
`endif
    repeat (2) @(negedge clk);
    check_eq("rst_act", 64'(|ActCoef), 64'd0);
    check_eq("rst_valid", 64'(CoefValid), 64'd0);
    check_eq("rst_pend", 64'(SwapPending), 64'd0);
    check_eq("rst_pulse", 64'(SwapPulse), 64'd0);
    check_eq("rst_err", 64'(CoefErr), 64'd0);
    Reset = 1'b0;
    @(negedge clk);

    // Full load with DpBusy low: pending after 15th write, swap one edge later
    for (int a = 0; a < 14; a++) push(a, a + 1, -(a + 1));
    check_eq("t1_pend_14", 64'(SwapPending), 64'd0);
    push(14, 15, -15);
    check_eq("t1_pend_15", 64'(SwapPending), 64'd1);
    check_eq("t1_pulse_early", 64'(SwapPulse), 64'd0);
    check_eq("t1_act_early", 64'($signed(ActCoef[14].I)), 64'd0);
    @(negedge clk);
    check_eq("t1_pulse", 64'(SwapPulse), 64'd1);
    check_eq("t1_act14_i", 64'($signed(ActCoef[14].I)), 64'(15));
    check_eq("t1_act14_q", 64'($signed(ActCoef[14].Q)), 64'(-15));
    check_eq("t1_act0_q", 64'($signed(ActCoef[0].Q)), 64'(-1));
    check_eq("t1_valid", 64'(CoefValid), 64'd1);
    check_eq("t1_pend_clr", 64'(SwapPending), 64'd0);
    @(negedge clk);
    check_eq("t1_pulse_once", 64'(SwapPulse), 64'd0);

`ifdef COEF_BANK_READBACK_EN
    RdAddr = 5'd14;
    @(negedge clk);
    check_eq("rb_i", 64'($signed(RdI)), 64'(15));
    check_eq("rb_q", 64'($signed(RdQ)), 64'(-15));
    RdAddr = 5'd20;
    @(negedge clk);
    check_eq("rb_oor", 64'($signed(RdI)), 64'd0);
`endif

    // Out-of-range writes: error pulse, nothing else moves
    push(20, 7, 0);
    check_eq("err20", 64'(CoefErr), 64'd1);
    check_eq("err20_pend", 64'(SwapPending), 64'd0);
    check_eq("err20_act", 64'($signed(ActCoef[14].I)), 64'(15));
    @(negedge clk);
    check_eq("err20_once", 64'(CoefErr), 64'd0);
    push(15, 7, 0);
    check_eq("err15", 64'(CoefErr), 64'd1);
    @(negedge clk);
    check_eq("err15_once", 64'(CoefErr), 64'd0);

    // Swap deferred while datapath is busy
    DpBusy = 1'b1;
    for (int a = 0; a < 14; a++) push(a, 100 + a, -(100 + a));
    check_eq("t2_mask_clean", 64'(SwapPending), 64'd0);
    push(14, 114, -114);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check_eq("t2_busy_pend", 64'(SwapPending), 64'd1);
      check_eq("t2_busy_hold", 64'($signed(ActCoef[0].I)), 64'(1));
    end
    DpBusy = 1'b0;
    @(negedge clk);
    check_eq("t2_pulse", 64'(SwapPulse), 64'd1);
    check_eq("t2_act0", 64'($signed(ActCoef[0].I)), 64'(100));
    check_eq("t2_act14_q", 64'($signed(ActCoef[14].Q)), 64'(-114));

    // Rewrite in PEND: last write wins
    DpBusy = 1'b1;
    load_set(200, -1);
    push(3, 99, -99);
    check_eq("t4_still_pend", 64'(SwapPending), 64'd1);
    DpBusy = 1'b0;
    @(negedge clk);
    check_eq("t4_act3", 64'($signed(ActCoef[3].I)), 64'(99));
    check_eq("t4_act4", 64'($signed(ActCoef[4].I)), 64'(204));

    // Write coincident with swap
    DpBusy = 1'b1;
    load_set(300, -1);
    DpBusy = 1'b0;
    push(5, 555, -555);
    check_eq("t5_pulse", 64'(SwapPulse), 64'd1);
    check_eq("t5_act5_old", 64'($signed(ActCoef[5].I)), 64'(305));
    check_eq("t5_pend", 64'(SwapPending), 64'd0);
    DpBusy = 1'b1;
    for (int a = 0; a < 14; a++) if (a != 5) push(a, 400 + a, -(400 + a));
    check_eq("t5_pend_13", 64'(SwapPending), 64'd0);
    push(14, 414, -414);
    check_eq("t5_pend_14", 64'(SwapPending), 64'd1);
    DpBusy = 1'b0;
    @(negedge clk);
    check_eq("t5_act5_new", 64'($signed(ActCoef[5].I)), 64'(555));
    check_eq("t5_act6", 64'($signed(ActCoef[6].I)), 64'(406));

    // Reset mid-load discards everything
    for (int a = 0; a < 7; a++) push(a, 500 + a, -(500 + a));
    Reset = 1'b1;
    #1;
    check_eq("t6_rst_act", 64'(|ActCoef), 64'd0);
    check_eq("t6_rst_valid", 64'(CoefValid), 64'd0);
    check_eq("t6_rst_pend", 64'(SwapPending), 64'd0);
    check_eq("t6_rst_pulse", 64'(SwapPulse), 64'd0);
    check_eq("t6_rst_err", 64'(CoefErr), 64'd0);
    @(negedge clk);
    Reset = 1'b0;
    @(negedge clk);
    for (int a = 7; a < 15; a++) push(a, 600 + a, -(600 + a));
    check_eq("t6_pend_8", 64'(SwapPending), 64'd0);
    for (int a = 0; a < 6; a++) push(a, 600 + a, -(600 + a));
    check_eq("t6_pend_14", 64'(SwapPending), 64'd0);
    push(6, 606, -606);
    check_eq("t6_pend_15", 64'(SwapPending), 64'd1);
    @(negedge clk);
    check_eq("t6_act0", 64'($signed(ActCoef[0].I)), 64'(600));
    check_eq("t6_valid", 64'(CoefValid), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/coef_bank_ctrl.md
# coef_bank_ctrl

Double-buffered coefficient manager for the complex symmetric FIR (firc). It accepts coefficient writes from the PushCoef port into a shadow bank and tracks which of the 15 unique taps have been written. It swaps the complete shadow bank into the active bank only when the FIR datapath is between output computations, so the datapath never sees a half-updated filter. The active bank drives the datapath coefficient inputs; the datapath mirrors taps k and 28-k.

## Interface
- NTAP_UNIQUE, 15, number of unique taps (29-tap symmetric filter).
- CW, 27, coefficient width per component, signed 3.24.
- clk  in  1  clock.
- Reset  in  1  reset, asynchronous, active-high.
- PushCoef  in  1  write strobe, one write per cycle.
- CoefAddr  in  5  tap address; 0..NTAP_UNIQUE-1 valid.
- CoefI, CoefQ  in  CW each  signed coefficient components.
- DpBusy  in  1  datapath computing an output (from control_fsm); swap is blocked while high.
- ActCoef  out  NTAP_UNIQUE x Coef  active bank (I,Q per tap).
- CoefValid  out  1  active bank holds at least one complete set.
- SwapPending  out  1  complete shadow set is waiting for a swap.
- SwapPulse  out  1  one-cycle pulse in the cycle after a swap.
- CoefErr  out  1  one-cycle pulse in the cycle after a write to an address of NTAP_UNIQUE or above.

## Operation
- Shadow bank: a write with CoefAddr < NTAP_UNIQUE stores CoefI/CoefQ at that address and sets mask[CoefAddr].
- A rewrite of an already-written address overwrites the value; the mask is unchanged.
- A write with CoefAddr >= NTAP_UNIQUE is discarded. CoefErr is 1 in the next cycle. The mask and state are unchanged.
- FSM states:
  - IDLE: mask empty.
  - LOAD: mask partial.
  - PEND: mask full.
- Transitions:
  - IDLE to LOAD on the first valid write.
  - LOAD to PEND when the mask becomes all-ones (including in the same cycle as the completing write).
  - PEND to IDLE on a swap.
- Swap condition: state==PEND and DpBusy==0, sampled at the clock edge. On the swap edge:
  - active is loaded from shadow;
  - the mask is cleared;
  - CoefValid is set to 1 and stays 1 until Reset;
  - SwapPulse is 1 for the following cycle.
- Writes while in PEND are accepted into the shadow bank (last write wins). The state stays PEND.
- A write in the same cycle as a swap:
  - active takes the pre-write shadow contents;
  - the written entry lands in shadow;
  - the mask becomes only that bit;
  - the next state is LOAD.
- The active bank never changes except on a swap edge or Reset.
- SwapPending is 1 exactly when state==PEND.

## Timing
- Reset values, all asynchronous:
  - shadow, active, mask = 0;
  - state = IDLE;
  - ActCoef = 0;
  - CoefValid, SwapPending, SwapPulse, CoefErr = 0.
- Reset mid-load or while in PEND discards everything. CoefValid returns to 0.
- Write latency: a shadow entry is updated at the edge where PushCoef is sampled.
- Completion to swap, with DpBusy held low:
  - the completing write is sampled at edge E;
  - SwapPending is high after E;
  - the swap happens at E+1;
  - ActCoef is updated and SwapPulse is high after E+1.
- Minimum latency from the completing write to active use is 2 edges.
- If DpBusy is high, the swap is deferred until the first edge with DpBusy low. There is no timeout.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Configuration
- COEF_BANK_READBACK_EN defined:
  - adds input RdAddr (5 bits) and outputs RdI, RdQ (CW bits each);
  - RdI/RdQ are registered reads of the active bank at RdAddr, with 1-cycle latency;
  - for RdAddr >= NTAP_UNIQUE, RdI/RdQ read as 0;
  - RdI/RdQ reset to 0.
- Not defined: these ports and registers are absent. All other behaviour is identical.

## Structure
- Shared package fir_structs holds:
  - the Coef struct (I, Q, signed CW);
  - the NTAP_UNIQUE and CW constants;
  - the bank-state enum (IDLE, LOAD, PEND).
- Sub-module coef_bank_reg: an NTAP_UNIQUE-entry Coef register file with write enable, address and async clear. It is instantiated once as shadow.
- The active bank is a plain parallel-load register in coef_bank_ctrl, loaded on a swap.
- The controller holds the mask, FSM, pulses and optional readback.

## Test plan
- Load addresses 0..14 with I=addr+1 and Q=-(addr+1), DpBusy=0 -> SwapPending high after the 15th write, then SwapPulse. ActCoef[14] is {15,-15} and CoefValid=1.
- Complete a set while DpBusy=1 for 10 cycles -> SwapPending stays high and ActCoef holds the old values for all 10 cycles. The swap happens at the first edge with DpBusy=0.
- Write address 20 with I=7 -> CoefErr pulses once. The mask, shadow and ActCoef are unchanged. Also write address 15 -> same response.
- While in PEND, rewrite address 3 with I=99 and then swap -> ActCoef[3].I=99.
- Write address 5 in the same cycle as a swap -> active holds the old shadow[5]. State is LOAD with mask=0x0020.
- Assert Reset after 7 writes, then load a full set -> all outputs are 0 during reset. The set completes only after 15 new writes.
- With COEF_BANK_READBACK_EN, RdAddr=14 after the first test -> RdI=15 and RdQ=-15 one cycle later.
